// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU plus iterative RV32M multiply/divide unit,
// registering every field the memory stage consumes.
module execute_stage #(
   parameter int XLEN     = 32,
   parameter int MDU_ITER = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            busywait_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            a_sel_i,
   input  logic            b_sel_i,
   input  logic [3:0]      alu_op_i,
   input  logic            is_long_i,
   input  logic [2:0]      mdu_op_i,
   input  logic [3:0]      op_type_i,
   input  logic            reg_wb_en_i,
   input  logic [4:0]      rd_label_i,
   input  logic [1:0]      wb_sel_i,
   input  logic            is_memory_instruction_i,
   output logic            stall_o,
   output logic [XLEN-1:0] alu_out_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic [3:0]      op_type_o,
   output logic            reg_wb_en_o,
   output logic [4:0]      rd_label_o,
   output logic [1:0]      wb_sel_o,
   output logic [XLEN-1:0] imm_o,
   output logic [XLEN-1:0] pc_o,
   output logic            is_memory_instruction_o,
   output logic            is_long_o
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(MDU_ITER);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} mdu_state_t;

   mdu_state_t      r_state;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_hi, r_lo, r_opb, r_dividend;
   logic [2:0]      r_op;
   logic            r_a_neg, r_b_neg, r_div_zero;

   logic [XLEN-1:0]   w_opa, w_opb, w_alu_res, w_mdu_res;
   logic [XLEN-1:0]   w_abs_a, w_abs_b, w_quot, w_rem;
   logic              w_sgn_a, w_sgn_b, w_a_neg, w_b_neg, w_div_ge;
   logic [XLEN:0]     w_mul_sum, w_div_trial, w_div_diff;
   logic [2*XLEN-1:0] w_prod, w_prod_s;

   assign stall_o = rst_ni & (((r_state == S_IDLE) & is_long_i) | (r_state == S_BUSY));

   assign w_opa = a_sel_i ? pc_i : rs1_data_i;
   assign w_opb = b_sel_i ? imm_i : rs2_data_i;

   // Single-cycle ALU result selection.
   always_comb begin
      w_alu_res = {XLEN{1'b0}};
      case (alu_op_i)
         4'd0:    w_alu_res = w_opa + w_opb;
         4'd1:    w_alu_res = w_opa - w_opb;
         4'd2:    w_alu_res = w_opa << w_opb[SW-1:0];
         4'd3:    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
         4'd4:    w_alu_res = {{(XLEN-1){1'b0}}, (w_opa < w_opb)};
         4'd5:    w_alu_res = w_opa ^ w_opb;
         4'd6:    w_alu_res = w_opa >> w_opb[SW-1:0];
         4'd7:    w_alu_res = $unsigned($signed(w_opa) >>> w_opb[SW-1:0]);
         4'd8:    w_alu_res = w_opa | w_opb;
         4'd9:    w_alu_res = w_opa & w_opb;
         4'd10:   w_alu_res = w_opb;
         default: w_alu_res = {XLEN{1'b0}};
      endcase
   end

   // Operand signedness: MULH/MULHSU/DIV/REM treat rs1 as signed, MULH/DIV/REM rs2.
   assign w_sgn_a = (mdu_op_i == 3'd1) | (mdu_op_i == 3'd2) | (mdu_op_i == 3'd4) | (mdu_op_i == 3'd6);
   assign w_sgn_b = (mdu_op_i == 3'd1) | (mdu_op_i == 3'd4) | (mdu_op_i == 3'd6);
   assign w_a_neg = w_sgn_a & rs1_data_i[XLEN-1];
   assign w_b_neg = w_sgn_b & rs2_data_i[XLEN-1];
   assign w_abs_a = w_a_neg ? ({XLEN{1'b0}} - rs1_data_i) : rs1_data_i;
   assign w_abs_b = w_b_neg ? ({XLEN{1'b0}} - rs2_data_i) : rs2_data_i;

   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
   assign w_div_trial = {r_hi, r_lo[XLEN-1]};
   assign w_div_diff  = w_div_trial - {1'b0, r_opb};
   assign w_div_ge    = (w_div_trial >= {1'b0, r_opb});

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = (r_a_neg ^ r_b_neg) ? ({(2*XLEN){1'b0}} - w_prod) : w_prod;
   assign w_quot   = (r_a_neg ^ r_b_neg) ? ({XLEN{1'b0}} - r_lo) : r_lo;
   assign w_rem    = r_a_neg ? ({XLEN{1'b0}} - r_hi) : r_hi;

   // Sign-corrected MDU result; divide-by-zero overrides the iterative value.
   always_comb begin
      w_mdu_res = {XLEN{1'b0}};
      case (r_op)
         3'd0:          w_mdu_res = w_prod_s[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:          w_mdu_res = w_prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:    w_mdu_res = r_div_zero ? {XLEN{1'b1}} : w_quot;
         3'd6, 3'd7:    w_mdu_res = r_div_zero ? r_dividend : w_rem;
         default:       w_mdu_res = {XLEN{1'b0}};
      endcase
   end

   // MDU sequencer: latch magnitudes, iterate one bit per cycle, then present result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_cnt      <= {CW{1'b0}};
         r_hi       <= {XLEN{1'b0}};
         r_lo       <= {XLEN{1'b0}};
         r_opb      <= {XLEN{1'b0}};
         r_dividend <= {XLEN{1'b0}};
         r_op       <= 3'd0;
         r_a_neg    <= 1'b0;
         r_b_neg    <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (is_long_i) begin
                  r_state    <= S_BUSY;
                  r_cnt      <= {CW{1'b0}};
                  r_hi       <= {XLEN{1'b0}};
                  r_lo       <= mdu_op_i[2] ? w_abs_a : w_abs_b;
                  r_opb      <= mdu_op_i[2] ? w_abs_b : w_abs_a;
                  r_dividend <= rs1_data_i;
                  r_op       <= mdu_op_i;
                  r_a_neg    <= w_a_neg;
                  r_b_neg    <= w_b_neg;
                  r_div_zero <= (rs2_data_i == {XLEN{1'b0}});
               end
            end
            S_BUSY: begin
               if (r_op[2]) begin
                  r_hi <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_trial[XLEN-1:0];
                  r_lo <= {r_lo[XLEN-2:0], w_div_ge};
               end else begin
                  r_hi <= w_mul_sum[XLEN:1];
                  r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
               end
               r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
               if (r_cnt == CW'(MDU_ITER - 1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (!busywait_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pipeline register toward the memory stage: hold, bubble, or load.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alu_out_o               <= {XLEN{1'b0}};
         rs2_data_o              <= {XLEN{1'b0}};
         op_type_o               <= 4'd0;
         reg_wb_en_o             <= 1'b0;
         rd_label_o              <= 5'd0;
         wb_sel_o                <= 2'd0;
         imm_o                   <= {XLEN{1'b0}};
         pc_o                    <= {XLEN{1'b0}};
         is_memory_instruction_o <= 1'b0;
         is_long_o               <= 1'b0;
      end else if (!busywait_i) begin
         if (stall_o) begin
            reg_wb_en_o             <= 1'b0;
            is_memory_instruction_o <= 1'b0;
            op_type_o               <= 4'd0;
            is_long_o               <= 1'b0;
         end else begin
            alu_out_o               <= (r_state == S_DONE) ? w_mdu_res : w_alu_res;
            rs2_data_o              <= rs2_data_i;
            op_type_o               <= op_type_i;
            reg_wb_en_o             <= reg_wb_en_i;
            rd_label_o              <= rd_label_i;
            wb_sel_o                <= wb_sel_i;
            imm_o                   <= imm_i;
            pc_o                    <= pc_i;
            is_memory_instruction_o <= is_memory_instruction_i;
            is_long_o               <= is_long_i;
         end
      end
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline stage directly upstream of the memory stage.
- Computes single-cycle ALU results and multi-cycle RV32M multiply/divide results.
- Registers all fields the memory stage consumes: alu_out, rs2 data, op type, writeback controls, imm, pc, is_long.
- Stalls the front end while the iterative multiply/divide unit (MDU) is busy, and honours memory-side busywait.

Parameters:
- XLEN, 32, datapath width.
- MDU_ITER, 32, MDU iteration cycles (one bit per cycle).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- busywait_i  in  1  memory stage stall; when high, all output registers hold.
- rs1_data_i  in  32  forwarded rs1 operand.
- rs2_data_i  in  32  forwarded rs2 operand.
- imm_i  in  32  immediate.
- pc_i  in  32  instruction PC.
- a_sel_i  in  1  operand A select: 0=rs1, 1=pc.
- b_sel_i  in  1  operand B select: 0=rs2, 1=imm.
- alu_op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; others give 0.
- is_long_i  in  1  instruction is an M-extension op.
- mdu_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_type_i  in  4  memory access type, passed through.
- reg_wb_en_i  in  1  passed through.
- rd_label_i  in  5  passed through.
- wb_sel_i  in  2  passed through.
- is_memory_instruction_i  in  1  passed through.
- stall_o  out  1  combinational; hold decode/fetch and this stage's inputs.
- alu_out_o  out  32  ALU or MDU result.
- rs2_data_o  out  32  registered rs2 data (store data).
- op_type_o, reg_wb_en_o, rd_label_o, wb_sel_o, imm_o, pc_o, is_memory_instruction_o, is_long_o  out  (4, 1, 5, 2, 32, 32, 1, 1)  registered pass-through fields.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - All outputs registers 0; MDU state IDLE; iteration counter 0.
  - stall_o is 0 while in reset.
- ALU path:
  - Shifts use B[4:0]; SLT is signed, SLTU unsigned; arithmetic wraps mod 2^32.
  - Result is registered with 1-cycle latency.
- MDU FSM, states IDLE, BUSY, DONE:
  - IDLE with is_long_i=1 (cycle T): stall_o=1. Latch |rs1| and |rs2| (signedness per op), result-sign flags and op. Go to BUSY, counter=0.
  - BUSY: stall_o=1. One shift-add (mul) or restoring-subtract (div) step per cycle. After MDU_ITER cycles (T+1..T+32) go to DONE.
  - DONE (T+33): stall_o=0. Apply sign correction and select the result. If busywait_i=0, load alu_out_o and go to IDLE; otherwise remain in DONE.
  - The next instruction is presented at T+34; a long op occupies the stage for 34 cycles.
  - is_long_i is ignored in BUSY and DONE.
- Output selection: MUL returns the low 32 bits of the product; MULH, MULHSU and MULHU return the high 32 bits with the appropriate signedness.
- Division corner cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend (the iterative result is overridden in DONE).
  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
  - Remainder takes the sign of the dividend.
- Output register update:
  - busywait_i=1: hold every output register; the FSM still advances through BUSY but stops in DONE.
  - busywait_i=0 and stall_o=1: load a bubble: reg_wb_en_o=0, is_memory_instruction_o=0, op_type_o=0, is_long_o=0; other fields hold.
  - busywait_i=0 and stall_o=0: load all fields from inputs; alu_out_o takes the MDU result in DONE, the ALU result otherwise.
- Reset mid-BUSY: the FSM returns to IDLE immediately, the partial result is discarded and no output is written.

Test Plan:
- rs1=5, rs2=0xFFFFFFFD, ADD with reg_wb_en_i=1 -> next cycle alu_out_o=0x00000002, reg_wb_en_o=1, stall_o stays 0.
- MUL 7 × 0xFFFFFFFD, is_long_i=1 at T -> stall_o=1 for T..T+32; alu_out_o=0xFFFFFFEB after T+33; bubbles (reg_wb_en_o=0) during the stall.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- DIV -7/2 with busywait_i=1 from T+30 to T+40 -> FSM holds DONE and outputs hold; alu_out_o=0xFFFFFFFD one cycle after busywait falls; REM -7/2 -> 0xFFFFFFFF.
- Assert rst_ni low at T+10 of a DIVU -> outputs 0 immediately; after release the FSM is IDLE and a following ADD completes in 1 cycle.
